// File: rtl/imem_pkg.sv
// Types and address helpers shared by the instruction-memory port arbiter and its decoders.
package imem_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LOAD    = 2'd1,
        RESTART = 2'd2
    } arb_state_e;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef struct packed {
        logic        legal;
        logic [31:0] word;
    } addr_dec_t;

    // Byte address -> word number, legal when word aligned and inside the memory.
    function automatic addr_dec_t decode_addr(input logic [31:0] addr, input int unsigned depth);
        addr_dec_t res;
        res.word  = {2'b00, addr[31:2]};
        res.legal = (addr[1:0] == 2'b00) && (res.word < depth);
        return res;
    endfunction

endpackage

// File: rtl/imem_addr_decode.sv
// Combinational byte-address to word-index conversion with legality check.
module imem_addr_decode
    import imem_pkg::*;
#(
    parameter int MEMORY_DEPTH = 64,
    parameter int AW           = $clog2(MEMORY_DEPTH)
) (
    input  logic [31:0]   addr_i,
    output logic          legal_o,
    output logic [AW-1:0] index_o
);

    addr_dec_t dec;

    assign dec     = decode_addr(addr_i, MEMORY_DEPTH);
    // Zero upper word bits make the truncated index unambiguous; the bound already implies it.
    assign legal_o = dec.legal && (dec.word[31:AW] == '0);
    assign index_o = dec.word[AW-1:0];

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares the instruction-memory port between fetch reads and loader writes; a load
// session stalls the core and finishes with a single-cycle restart pulse.
module imem_port_arbiter
    import imem_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    MEMORY_DEPTH = 64,
    parameter int                    AW           = $clog2(MEMORY_DEPTH),
    parameter logic [DATA_WIDTH-1:0] NOP_INSN     = imem_pkg::NOP_INSN
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_req_i,
    input  logic [31:0]           fetch_addr_i,
    output logic                  fetch_gnt_o,
    output logic                  fetch_rvalid_o,
    output logic [DATA_WIDTH-1:0] fetch_rdata_o,
    output logic                  fetch_err_o,
    input  logic                  load_req_i,
    input  logic [31:0]           load_addr_i,
    input  logic [DATA_WIDTH-1:0] load_wdata_i,
    input  logic                  load_last_i,
    output logic                  load_gnt_o,
    output logic                  load_err_o,
    output logic [AW:0]           load_count_o,
    output logic                  cpu_stall_o,
    output logic                  cpu_restart_o,
    output logic [AW-1:0]         mem_addr_o,
    output logic                  mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam logic [AW:0] COUNT_MAX = (AW+1)'(MEMORY_DEPTH);

    arb_state_e            state_q, state_d;
    logic [AW:0]           load_count_q, load_count_d;
    logic                  fetch_rvalid_q, fetch_err_q, load_err_q;
    logic [DATA_WIDTH-1:0] fetch_rdata_q;

    logic                  fetch_legal, load_legal;
    logic [AW-1:0]         fetch_idx, load_idx;
    logic                  fetch_gnt, load_gnt;
    logic [AW-1:0]         mem_addr;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_wdata;

    imem_addr_decode #(.MEMORY_DEPTH(MEMORY_DEPTH), .AW(AW)) u_fetch_dec (
        .addr_i  (fetch_addr_i),
        .legal_o (fetch_legal),
        .index_o (fetch_idx)
    );

    imem_addr_decode #(.MEMORY_DEPTH(MEMORY_DEPTH), .AW(AW)) u_load_dec (
        .addr_i  (load_addr_i),
        .legal_o (load_legal),
        .index_o (load_idx)
    );

    // Grants are suppressed while reset is held so no write can commit on a reset edge.
    always_comb begin
        state_d      = state_q;
        load_count_d = load_count_q;
        fetch_gnt    = 1'b0;
        load_gnt     = 1'b0;
        mem_addr     = '0;
        mem_we       = 1'b0;
        mem_wdata    = '0;
        unique case (state_q)
            RUN: begin
                fetch_gnt = fetch_req_i && !load_req_i && !reset;
                if (fetch_gnt && fetch_legal) begin
                    mem_addr = fetch_idx;
                end
                if (load_req_i) begin
                    state_d      = LOAD;
                    load_count_d = '0;
                end
            end
            LOAD: begin
                load_gnt = load_req_i && !reset;
                if (load_gnt) begin
                    if (load_legal) begin
                        mem_we    = 1'b1;
                        mem_addr  = load_idx;
                        mem_wdata = load_wdata_i;
                        if (load_count_q != COUNT_MAX) begin
                            load_count_d = load_count_q + 1'b1;
                        end
                    end
                    if (load_last_i) begin
                        state_d = RESTART;
                    end
                end
            end
            RESTART: state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= RUN;
            load_count_q   <= '0;
            fetch_rvalid_q <= 1'b0;
            fetch_err_q    <= 1'b0;
            fetch_rdata_q  <= '0;
            load_err_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            load_count_q   <= load_count_d;
            fetch_rvalid_q <= fetch_gnt;
            fetch_err_q    <= fetch_gnt && !fetch_legal;
            load_err_q     <= load_gnt && !load_legal;
            if (fetch_gnt) begin
                fetch_rdata_q <= fetch_legal ? mem_rdata_i : NOP_INSN;
            end
        end
    end

    assign fetch_gnt_o    = fetch_gnt;
    assign fetch_rvalid_o = fetch_rvalid_q;
    assign fetch_rdata_o  = fetch_rdata_q;
    assign fetch_err_o    = fetch_err_q;
    assign load_gnt_o     = load_gnt;
    assign load_err_o     = load_err_q;
    assign load_count_o   = load_count_q;
    assign cpu_stall_o    = (state_q != RUN);
    assign cpu_restart_o  = (state_q == RESTART);
    assign mem_addr_o     = mem_addr;
    assign mem_we_o       = mem_we;
    assign mem_wdata_o    = mem_wdata;

endmodule
